// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles 32-bit words from a byte-wide read port
// and holds each (inst, pc) pair until decode accepts it.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_in,
    input  logic        jump_en_in,
    input  logic [31:0] jump_addr_in,
    output logic        mem_rd_en_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_ready_in,
    input  logic [7:0]  mem_data_in,
    output logic        inst_valid_out,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out
);

    typedef enum logic {FETCH, HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] inst, inst_n;
    logic [31:0] addr, addr_n;
    logic [2:0]  issue, issue_n;
    logic [2:0]  rcv, rcv_n;
    logic        pend, pend_n;
    logic        valid, valid_n;
    logic        rd_en, rd_en_n;
    logic        accept;

    assign accept = rd_en & mem_ready_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= RESET_PC;
            inst  <= '0;
            addr  <= '0;
            issue <= '0;
            rcv   <= '0;
            pend  <= 1'b0;
            valid <= 1'b0;
            rd_en <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            inst  <= inst_n;
            addr  <= addr_n;
            issue <= issue_n;
            rcv   <= rcv_n;
            pend  <= pend_n;
            valid <= valid_n;
            rd_en <= rd_en_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        inst_n  = inst;
        issue_n = issue;
        rcv_n   = rcv;
        pend_n  = accept;
        valid_n = valid;

        if (accept) issue_n = issue + 3'd1;

        if (pend && !rcv[2]) begin
            inst_n[{rcv[1:0], 3'b000} +: 8] = mem_data_in;
            rcv_n = rcv + 3'd1;
        end

        unique case (state)
            FETCH: begin
                if (rcv_n == 3'd4) begin
                    state_n = HOLD;
                    valid_n = 1'b1;
                end
            end
            HOLD: begin
                if (valid && !stall_in) begin
                    pc_n    = pc + 32'd4;
                    issue_n = '0;
                    rcv_n   = '0;
                    valid_n = 1'b0;
                    state_n = FETCH;
                end
            end
        endcase

        // Redirect overrides everything, including a same-edge handshake.
        if (jump_en_in) begin
            pc_n    = {jump_addr_in[31:2], 2'b00};
            issue_n = '0;
            rcv_n   = '0;
            pend_n  = 1'b0;
            valid_n = 1'b0;
            state_n = FETCH;
        end

        // Request outputs are registered from next-state values.
        rd_en_n = (state_n == FETCH) && (issue_n < 3'd4);
        addr_n  = pc_n + {29'b0, issue_n};
    end

    assign mem_rd_en_out  = rd_en;
    assign mem_addr_out   = addr;
    assign inst_valid_out = valid;
    assign inst_out       = inst;
    assign pc_out         = pc;

endmodule
